unified_mem_responder: RTL and testbench

- Synthesizable responder end of the CPU memory/register interface: serves instruction fetch, two register-operand reads, one register write-back and one data load/store per request from `Top`.
- Storage is a single-port, byte-addressed, little-endian array.
- Register xN lives at byte 4*N, so the register file and data memory share one space. Reading x0 returns 0; writes to x0 are dropped.
- A fixed-sequence FSM serialises all accesses onto the single port and returns results with a done pulse.

---
 rtl/unified_mem_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_unified_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_responder.sv
// Memory/register responder: serialises IF, RS1, RS2, MEM and WB onto one byte-addressed little-endian port.
// Latency: done is high in the 6th cycle after the edge that accepts req; the next req is accepted one cycle after DONE.
// Backpressure: requests are only accepted in IDLE; req and dbg_we are ignored while busy.
module unified_mem_responder #(
    parameter int MEM_SIZE = 512,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] ins_addr,
    input  logic [31:0] load_pc_reg_addr1,
    input  logic [31:0] load_pc_reg_addr2,
    input  logic        op_write_top,
    input  logic [31:0] write_pc_reg_addr,
    input  logic [31:0] write_pc_reg_value,
    input  logic [1:0]  mem_ctrl_input,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] ins_data,
    output logic [31:0] load_pc_reg_value1,
    output logic [31:0] load_pc_reg_value2,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          AW        = $clog2(MEM_SIZE);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);
    localparam logic [31:0] REG_LIMIT = 32'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_RS1,
        S_RS2,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Request fields captured at accept so the requester may change its inputs afterwards
    logic [31:0] ins_addr_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic        we_q;
    logic [31:0] rd_q;
    logic [31:0] rd_val_q;
    logic [1:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Registered outputs and their next-state values
    logic [31:0] ins_data_q, ins_data_d;
    logic [31:0] val1_q, val1_d;
    logic [31:0] val2_q, val2_d;
    logic [31:0] read_data_q, read_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Storage and its single access port
    logic [7:0]    mem_q [MEM_SIZE];
    logic [AW-1:0] port_idx;
    logic          port_we;
    logic [31:0]   port_wdata;
    logic [31:0]   port_rdata;
    logic [AW-1:0] idx1, idx2, idx3;

    // A word access is legal when aligned and entirely inside the array
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < MEM_LIMIT);
    endfunction

    function automatic logic reg_ok(input logic [31:0] i);
        return i < REG_LIMIT;
    endfunction

    assign idx1       = port_idx + AW'(1);
    assign idx2       = port_idx + AW'(2);
    assign idx3       = port_idx + AW'(3);
    assign port_rdata = {mem_q[idx3], mem_q[idx2], mem_q[idx1], mem_q[port_idx]};

    // State register; reset aborts any request in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed access sequence; only IDLE waits on an input
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = req ? S_IF : S_IDLE;
            S_IF:    state_d = S_RS1;
            S_RS1:   state_d = S_RS2;
            S_RS2:   state_d = S_MEM;
            S_MEM:   state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Port owner per state: preload in idle, otherwise the access belonging to the current step
    always_comb begin
        port_idx   = '0;
        port_we    = 1'b0;
        port_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (!req && dbg_we && addr_ok(dbg_addr)) begin
                    port_idx   = dbg_addr[AW-1:0];
                    port_we    = 1'b1;
                    port_wdata = dbg_wdata;
                end
            end
            S_IF:  port_idx = ins_addr_q[AW-1:0];
            S_RS1: port_idx = {rs1_q[AW-3:0], 2'b00};
            S_RS2: port_idx = {rs2_q[AW-3:0], 2'b00};
            S_MEM: begin
                port_idx   = addr_q[AW-1:0];
                port_we    = (ctrl_q == 2'b01) && addr_ok(addr_q);
                port_wdata = wdata_q;
            end
            S_WB: begin
                port_idx   = {rd_q[AW-3:0], 2'b00};
                port_we    = we_q && (rd_q != 32'd0) && reg_ok(rd_q);
                port_wdata = rd_val_q;
            end
            default: ;
        endcase
    end

    // Output next-state: each step updates only its own result; errors accumulate until the next accept
    always_comb begin
        ins_data_d  = ins_data_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        read_data_d = read_data_q;
        err_d       = err_q;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    err_d = 1'b0;
                end
            end
            S_IF: begin
                if (addr_ok(ins_addr_q)) begin
                    ins_data_d = port_rdata;
                end else begin
                    ins_data_d = '0;
                    err_d      = 1'b1;
                end
            end
            S_RS1: begin
                if (!reg_ok(rs1_q)) begin
                    val1_d = '0;
                    err_d  = 1'b1;
                end else if (rs1_q == 32'd0) begin
                    val1_d = '0;
                end else begin
                    val1_d = port_rdata;
                end
            end
            S_RS2: begin
                if (!reg_ok(rs2_q)) begin
                    val2_d = '0;
                    err_d  = 1'b1;
                end else if (rs2_q == 32'd0) begin
                    val2_d = '0;
                end else begin
                    val2_d = port_rdata;
                end
            end
            S_MEM: begin
                unique case (ctrl_q)
                    2'b11: err_d = 1'b1;
                    2'b10: begin
                        if (addr_ok(addr_q)) begin
                            read_data_d = port_rdata;
                        end else begin
                            read_data_d = '0;
                            err_d       = 1'b1;
                        end
                    end
                    2'b01: begin
                        if (!addr_ok(addr_q)) begin
                            err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                if (we_q && (rd_q != 32'd0) && !reg_ok(rd_q)) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_data_q  <= '0;
            val1_q      <= '0;
            val2_q      <= '0;
            read_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ins_data_q  <= ins_data_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Latch the whole request on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_addr_q <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            rd_val_q   <= '0;
            ctrl_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if ((state_q == S_IDLE) && req) begin
            ins_addr_q <= ins_addr;
            rs1_q      <= load_pc_reg_addr1;
            rs2_q      <= load_pc_reg_addr2;
            we_q       <= op_write_top;
            rd_q       <= write_pc_reg_addr;
            rd_val_q   <= write_pc_reg_value;
            ctrl_q     <= mem_ctrl_input;
            addr_q     <= address;
            wdata_q    <= w_data;
        end
    end

    // Array write, little-endian; the array is never cleared and no write lands while reset is held
    always_ff @(posedge clk) begin
        if (port_we && !reset) begin
            mem_q[port_idx] <= port_wdata[7:0];
            mem_q[idx1]     <= port_wdata[15:8];
            mem_q[idx2]     <= port_wdata[23:16];
            mem_q[idx3]     <= port_wdata[31:24];
        end
    end

    assign ins_data           = ins_data_q;
    assign load_pc_reg_value1 = val1_q;
    assign load_pc_reg_value2 = val2_q;
    assign read_data          = read_data_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] ins_addr;
    logic [31:0] load_pc_reg_addr1;
    logic [31:0] load_pc_reg_addr2;
    logic        op_write_top;
    logic [31:0] write_pc_reg_addr;
    logic [31:0] write_pc_reg_value;
    logic [1:0]  mem_ctrl_input;
    logic [31:0] address;
    logic [31:0] w_data;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] ins_data;
    logic [31:0] load_pc_reg_value1;
    logic [31:0] load_pc_reg_value2;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    // Reference model: flat byte array plus the last value seen on each output
    logic [7:0]  mm [512];
    logic [31:0] e_ins, e_v1, e_v2, e_rd;
    logic        e_err;

    unified_mem_responder #(.MEM_SIZE(512), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .req(req),
        .ins_addr(ins_addr),
        .load_pc_reg_addr1(load_pc_reg_addr1), .load_pc_reg_addr2(load_pc_reg_addr2),
        .op_write_top(op_write_top),
        .write_pc_reg_addr(write_pc_reg_addr), .write_pc_reg_value(write_pc_reg_value),
        .mem_ctrl_input(mem_ctrl_input), .address(address), .w_data(w_data),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .ins_data(ins_data),
        .load_pc_reg_value1(load_pc_reg_value1), .load_pc_reg_value2(load_pc_reg_value2),
        .read_data(read_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic aok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd512);
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        int b;
        b = int'(a);
        return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    endfunction

    task automatic mwrite(input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a);
        mm[b]   = d[7:0];
        mm[b+1] = d[15:8];
        mm[b+2] = d[23:16];
        mm[b+3] = d[31:24];
    endtask

    task automatic reg_read(input logic [31:0] r, output logic [31:0] v);
        if (r >= 32'd32) begin
            v     = 32'd0;
            e_err = 1'b1;
        end else if (r == 32'd0) begin
            v = 32'd0;
        end else begin
            v = mword(r * 32'd4);
        end
    endtask

    // One request applied to the model in program order: fetch, two reads, data op, write-back
    task automatic model_req(input logic [31:0] ia, r1, r2, input logic wen,
                             input logic [31:0] rd, rv, input logic [1:0] ctl,
                             input logic [31:0] ad, wd);
        e_err = 1'b0;
        if (aok(ia)) e_ins = mword(ia);
        else begin e_ins = 32'd0; e_err = 1'b1; end
        reg_read(r1, e_v1);
        reg_read(r2, e_v2);
        if (ctl == 2'b11) e_err = 1'b1;
        else if (ctl == 2'b10) begin
            if (aok(ad)) e_rd = mword(ad);
            else begin e_rd = 32'd0; e_err = 1'b1; end
        end else if (ctl == 2'b01) begin
            if (aok(ad)) mwrite(ad, wd);
            else e_err = 1'b1;
        end
        if (wen && rd != 32'd0) begin
            if (rd < 32'd32) mwrite(rd * 32'd4, rv);
            else e_err = 1'b1;
        end
    endtask

    task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
        dbg_addr  = a;
        dbg_wdata = d;
        dbg_we    = 1'b1;
        tick();
        dbg_we = 1'b0;
        if (aok(a)) mwrite(a, d);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ins_data"}, ins_data, e_ins);
        chk({tag, ".value1"}, load_pc_reg_value1, e_v1);
        chk({tag, ".value2"}, load_pc_reg_value2, e_v2);
        chk({tag, ".read_data"}, read_data, e_rd);
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    task automatic run_req(input string tag, input logic [31:0] ia, r1, r2, input logic wen,
                           input logic [31:0] rd, rv, input logic [1:0] ctl,
                           input logic [31:0] ad, wd);
        int  n;
        bit  seen;
        model_req(ia, r1, r2, wen, rd, rv, ctl, ad, wd);
        ins_addr = ia; load_pc_reg_addr1 = r1; load_pc_reg_addr2 = r2;
        op_write_top = wen; write_pc_reg_addr = rd; write_pc_reg_value = rv;
        mem_ctrl_input = ctl; address = ad; w_data = wd;
        req = 1'b1;
        tick();
        req = 1'b0;
        ins_addr = $urandom; load_pc_reg_addr1 = $urandom; load_pc_reg_addr2 = $urandom;
        op_write_top = 1'($urandom); write_pc_reg_addr = $urandom; write_pc_reg_value = $urandom;
        mem_ctrl_input = 2'($urandom); address = $urandom; w_data = $urandom;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n    = 1;
        seen = done;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = done;
        end
        chk({tag, ".done_latency"}, 32'(n), 32'd6);
        check_outputs(tag);
        tick();
        chk({tag, ".done_width"}, 32'(done), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7) return {21'd0, 9'($urandom_range(0, 127)), 2'b00};
        else if (sel < 9) return 32'($urandom_range(0, 511));
        else return 32'($urandom_range(512, 1023));
    endfunction

    initial begin
        int npulse, first, second, aborted_done;
        reset = 1'b1; req = 1'b0; ins_addr = '0; load_pc_reg_addr1 = '0; load_pc_reg_addr2 = '0;
        op_write_top = 1'b0; write_pc_reg_addr = '0; write_pc_reg_value = '0;
        mem_ctrl_input = '0; address = '0; w_data = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        e_ins = '0; e_v1 = '0; e_v2 = '0; e_rd = '0; e_err = 1'b0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_outputs("reset");
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);

        // Preload the whole array, then the directed values
        for (int w = 0; w < 128; w++) dbg_write(32'(w * 4), $urandom);
        dbg_write(32'h100, 32'h0050_0093);
        dbg_write(32'h004, 32'd5);
        dbg_write(32'h008, 32'd7);
        dbg_write(32'h180, 32'hCAFE_BABE);
        dbg_write(32'h041, 32'hDEAD_0001);
        dbg_write(32'h204, 32'hDEAD_0002);

        // Full request
        run_req("full", 32'h100, 1, 2, 1'b1, 3, 32'd12, 2'b10, 32'h180, 32'h0);
        chk("full.ins_direct", ins_data, 32'h0050_0093);
        chk("full.rd_direct", read_data, 32'hCAFE_BABE);
        run_req("x3_after_wb", 32'h100, 3, 0, 1'b0, 0, 32'h0, 2'b00, 32'h0, 32'h0);
        chk("x3_after_wb.direct", load_pc_reg_value1, 32'd12);

        // Dropped dbg writes: unaligned and out of range
        run_req("dbg_drop", 32'h040, 0, 0, 1'b0, 0, 32'h0, 2'b10, 32'h040, 32'h0);

        // x0 and ordering
        dbg_write(32'h00C, 32'd9);
        run_req("order", 32'h100, 0, 3, 1'b1, 3, 32'h55, 2'b00, 32'h0, 32'h0);
        chk("order.old_x3", load_pc_reg_value2, 32'd9);
        run_req("x0_wr", 32'h100, 3, 0, 1'b1, 0, 32'hDEAD_BEEF, 2'b00, 32'h0, 32'h0);
        chk("x0_wr.x3_new", load_pc_reg_value1, 32'h55);
        run_req("x0_rd", 32'h100, 0, 0, 1'b0, 0, 32'h0, 2'b00, 32'h0, 32'h0);

        // Byte order
        run_req("store_1f0", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b01, 32'h1F0, 32'h1122_3344);
        chk("byte0", 32'(dut.mem_q['h1F0]), 32'h44);
        chk("byte1", 32'(dut.mem_q['h1F1]), 32'h33);
        chk("byte2", 32'(dut.mem_q['h1F2]), 32'h22);
        chk("byte3", 32'(dut.mem_q['h1F3]), 32'h11);
        run_req("load_1f1", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b10, 32'h1F1, 32'h0);
        run_req("load_1f0", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b10, 32'h1F0, 32'h0);

        // Error cases, each followed by a clean request
        run_req("illegal_ctl", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b11, 32'h1F0, 32'h9999_9999);
        run_req("after_illegal", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b10, 32'h1F0, 32'h0);
        run_req("oob_load", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b10, 32'h200, 32'h0);
        run_req("rd40", 32'h100, 1, 2, 1'b1, 40, 32'h7777, 2'b00, 32'h0, 32'h0);
        run_req("rs_oob", 32'h102, 33, 2, 1'b0, 0, 32'h0, 2'b01, 32'h203, 32'h1);
        run_req("clean", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b00, 32'h0, 32'h0);

        // Reset during RS2 of a store
        ins_addr = 32'h100; load_pc_reg_addr1 = 1; load_pc_reg_addr2 = 2;
        op_write_top = 1'b1; write_pc_reg_addr = 5; write_pc_reg_value = 32'h1234;
        mem_ctrl_input = 2'b01; address = 32'h100; w_data = 32'hAABB_CCDD;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #2;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        #1;
        reset = 1'b0;
        e_ins = '0; e_v1 = '0; e_v2 = '0; e_rd = '0; e_err = 1'b0;
        check_outputs("abort");
        aborted_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) aborted_done++;
        end
        chk("abort.no_done", 32'(aborted_done), 32'd0);
        run_req("abort_mem", 32'h100, 5, 0, 1'b0, 0, 32'h0, 2'b10, 32'h100, 32'h0);
        chk("abort_mem.direct", read_data, 32'h0050_0093);

        // req held for 14 cycles; dbg_we pulsed while busy
        ins_addr = 32'h180; load_pc_reg_addr1 = 1; load_pc_reg_addr2 = 2;
        op_write_top = 1'b0; write_pc_reg_addr = 0; write_pc_reg_value = 0;
        mem_ctrl_input = 2'b00; address = 0; w_data = 0;
        model_req(32'h180, 1, 2, 1'b0, 0, 0, 2'b00, 0, 0);
        model_req(32'h180, 1, 2, 1'b0, 0, 0, 2'b00, 0, 0);
        npulse = 0; first = -1; second = -1;
        req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                dbg_we = 1'b1; dbg_addr = 32'h1F0; dbg_wdata = 32'h5A5A_5A5A;
            end
            tick();
            dbg_we = 1'b0;
            if (c == 14) req = 1'b0;
            if (done) begin
                npulse++;
                if (first < 0) first = c;
                else second = c;
            end
        end
        chk("held.pulses", 32'(npulse), 32'd2);
        chk("held.first", 32'(first), 32'd6);
        chk("held.spacing", 32'(second - first), 32'd7);
        check_outputs("held");
        run_req("dbg_busy", 32'h100, 1, 2, 1'b0, 0, 32'h0, 2'b10, 32'h1F0, 32'h0);

        // Randomized requests against the model
        for (int k = 0; k < 40; k++) begin
            run_req("rand", rnd_addr(), 32'($urandom_range(0, 35)), 32'($urandom_range(0, 35)),
                    1'($urandom), 32'($urandom_range(0, 40)), $urandom,
                    2'($urandom), rnd_addr(), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
